cve2_data_sram_bridge: RTL and testbench

// Sits directly downstream of cve2_core's data memory port: terminates the core's req/gnt/rvalid

---
 rtl/cve2_data_sram_bridge.sv | 111 +++++++++++
 tb/tb_cve2_data_sram_bridge.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cve2_data_sram_bridge.sv
// Data-side bridge from the cve2 core's req/gnt/rvalid port onto an arbitrated single-port SRAM.
// Range-checks each access, answers out-of-window accesses with a bus error, and counts traffic.
module cve2_data_sram_bridge #(
  parameter logic [31:0] BaseAddr  = 32'h1000_0000,
  parameter int unsigned NumWords  = 1024,
  parameter int unsigned AddrWidth = 10,
  parameter int unsigned CntWidth  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  // core data port
  input  logic                 data_req_i,
  output logic                 data_gnt_o,
  input  logic                 data_we_i,
  input  logic [3:0]           data_be_i,
  input  logic [31:0]          data_addr_i,
  input  logic [31:0]          data_wdata_i,
  output logic                 data_rvalid_o,
  output logic [31:0]          data_rdata_o,
  output logic                 data_err_o,
  // SRAM port
  output logic                 sram_req_o,
  input  logic                 sram_gnt_i,
  output logic                 sram_we_o,
  output logic [3:0]           sram_be_o,
  output logic [AddrWidth-1:0] sram_addr_o,
  output logic [31:0]          sram_wdata_o,
  input  logic [31:0]          sram_rdata_i,
  // debug / perf
  output logic [CntWidth-1:0]  rd_cnt_o,
  output logic [CntWidth-1:0]  wr_cnt_o,
  output logic [CntWidth-1:0]  err_cnt_o,
  output logic                 busy_o
);

  logic [31:0] w_offset;
  logic [31:0] w_word_idx;
  logic        w_in_range;
  logic        w_req;
  logic        w_gnt;
  logic        w_gnt_rd;
  logic        w_gnt_wr;
  logic        w_gnt_err;

  logic                r_rsp_valid;
  logic                r_rsp_err;
  logic                r_was_read;
  logic [CntWidth-1:0] r_rd_cnt;
  logic [CntWidth-1:0] r_wr_cnt;
  logic [CntWidth-1:0] r_err_cnt;

  // The lower-bound compare stops a wrapped subtraction from aliasing into the window.
  assign w_offset   = data_addr_i - BaseAddr;
  assign w_word_idx = w_offset >> 2;
  assign w_in_range = (data_addr_i >= BaseAddr) && (w_word_idx < NumWords);

  assign w_req      = data_req_i & ~rst_i;
  assign w_gnt      = w_req & (w_in_range ? sram_gnt_i : 1'b1);
  assign w_gnt_rd   = w_gnt & w_in_range & ~data_we_i;
  assign w_gnt_wr   = w_gnt & w_in_range & data_we_i;
  assign w_gnt_err  = w_gnt & ~w_in_range;

  assign data_gnt_o   = w_gnt;
  assign sram_req_o   = w_req & w_in_range;
  assign sram_we_o    = data_we_i;
  assign sram_be_o    = data_be_i;
  assign sram_addr_o  = w_word_idx[AddrWidth-1:0];
  assign sram_wdata_o = data_wdata_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_was_read  <= 1'b0;
    end else begin
      r_rsp_valid <= w_gnt;
      r_rsp_err   <= w_gnt_err;
      r_was_read  <= w_gnt_rd;
    end
  end

  // Saturating counters: hold at all-ones instead of wrapping.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rd_cnt  <= '0;
      r_wr_cnt  <= '0;
      r_err_cnt <= '0;
    end else begin
      if (w_gnt_rd && !(&r_rd_cnt)) begin
        r_rd_cnt <= r_rd_cnt + CntWidth'(1);
      end
      if (w_gnt_wr && !(&r_wr_cnt)) begin
        r_wr_cnt <= r_wr_cnt + CntWidth'(1);
      end
      if (w_gnt_err && !(&r_err_cnt)) begin
        r_err_cnt <= r_err_cnt + CntWidth'(1);
      end
    end
  end

  // Masking with rst_i drops a response whose cycle coincides with reset.
  assign data_rvalid_o = r_rsp_valid & ~rst_i;
  assign busy_o        = r_rsp_valid & ~rst_i;
  assign data_err_o    = r_rsp_err & ~rst_i;
  assign data_rdata_o  = (r_was_read & ~rst_i) ? sram_rdata_i : 32'h0;

  assign rd_cnt_o  = r_rd_cnt;
  assign wr_cnt_o  = r_wr_cnt;
  assign err_cnt_o = r_err_cnt;

endmodule

// File: tb/tb_cve2_data_sram_bridge.sv
// Directed self-checking bench for cve2_data_sram_bridge; a second instance with CntWidth=2
// shares the stimulus to exercise counter saturation.
module tb_cve2_data_sram_bridge;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        data_req_i;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_wdata_i;
  logic        sram_gnt_i;
  logic [31:0] sram_rdata_i;

  logic        data_gnt_o, data_rvalid_o, data_err_o, sram_req_o, sram_we_o, busy_o;
  logic [31:0] data_rdata_o, sram_wdata_o;
  logic [3:0]  sram_be_o;
  logic [9:0]  sram_addr_o;
  logic [15:0] rd_cnt_o, wr_cnt_o, err_cnt_o;

  logic        s_gnt, s_rvalid, s_err, s_sreq, s_swe, s_busy;
  logic [31:0] s_rdata, s_swdata;
  logic [3:0]  s_sbe;
  logic [9:0]  s_saddr;
  logic [1:0]  s_rd_cnt, s_wr_cnt, s_err_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_rd = 0;
  int exp_wr = 0;
  int exp_err = 0;

  always #5 clk_i = ~clk_i;

  cve2_data_sram_bridge dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .data_req_i(data_req_i), .data_gnt_o(data_gnt_o), .data_we_i(data_we_i),
    .data_be_i(data_be_i), .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
    .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
    .sram_req_o(sram_req_o), .sram_gnt_i(sram_gnt_i), .sram_we_o(sram_we_o),
    .sram_be_o(sram_be_o), .sram_addr_o(sram_addr_o), .sram_wdata_o(sram_wdata_o),
    .sram_rdata_i(sram_rdata_i),
    .rd_cnt_o(rd_cnt_o), .wr_cnt_o(wr_cnt_o), .err_cnt_o(err_cnt_o), .busy_o(busy_o)
  );

  cve2_data_sram_bridge #(.CntWidth(2)) dut_sat (
    .clk_i(clk_i), .rst_i(rst_i),
    .data_req_i(data_req_i), .data_gnt_o(s_gnt), .data_we_i(data_we_i),
    .data_be_i(data_be_i), .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
    .data_rvalid_o(s_rvalid), .data_rdata_o(s_rdata), .data_err_o(s_err),
    .sram_req_o(s_sreq), .sram_gnt_i(sram_gnt_i), .sram_we_o(s_swe),
    .sram_be_o(s_sbe), .sram_addr_o(s_saddr), .sram_wdata_o(s_swdata),
    .sram_rdata_i(sram_rdata_i),
    .rd_cnt_o(s_rd_cnt), .wr_cnt_o(s_wr_cnt), .err_cnt_o(s_err_cnt), .busy_o(s_busy)
  );

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic req, input logic we, input logic [31:0] addr,
                       input logic [3:0] be, input logic [31:0] wdata);
    data_req_i   = req;
    data_we_i    = we;
    data_addr_i  = addr;
    data_be_i    = be;
    data_wdata_i = wdata;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    sram_gnt_i = 1'b1;
    drive(1'b1, 1'b0, 32'h1000_0000, 4'hF, 32'h0);
    next_cycle();
    next_cycle();
    n_cmp++; if (sram_req_o !== 1'b0) begin n_bad++; $display("FAIL rst_sram_req: got %b want 0", sram_req_o); end
    n_cmp++; if (data_rvalid_o !== 1'b0 || busy_o !== 1'b0 || data_err_o !== 1'b0) begin
      n_bad++; $display("FAIL rst_flags: rvalid=%b busy=%b err=%b want 0", data_rvalid_o, busy_o, data_err_o);
    end
    n_cmp++; if (data_rdata_o !== 32'h0) begin n_bad++; $display("FAIL rst_rdata: got %h want 0", data_rdata_o); end
    n_cmp++; if ({rd_cnt_o, wr_cnt_o, err_cnt_o} !== 48'h0) begin
      n_bad++; $display("FAIL rst_cnt: got %h %h %h want 0", rd_cnt_o, wr_cnt_o, err_cnt_o);
    end
    drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    rst_i = 1'b0;
    next_cycle();
  endtask

  task automatic test_saturation();
    sram_gnt_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 32'h1000_0000 + 32'(4 * i), 4'hF, 32'h0);
      next_cycle();
      n_cmp++; if (rd_cnt_o !== 16'(i + 1)) begin
        n_bad++; $display("FAIL sat_cnt16[%0d]: got %0d want %0d", i, rd_cnt_o, i + 1);
      end
      n_cmp++; if (s_rd_cnt !== ((i >= 2) ? 2'd3 : 2'(i + 1))) begin
        n_bad++; $display("FAIL sat_cnt2[%0d]: got %0d want %0d", i, s_rd_cnt, (i >= 2) ? 3 : i + 1);
      end
    end
    drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    next_cycle();
  endtask

  task automatic test_reset_drop();
    sram_gnt_i = 1'b1;
    sram_rdata_i = 32'hCAFE_F00D;
    drive(1'b1, 1'b0, 32'h1000_0020, 4'hF, 32'h0);
    next_cycle();
    rst_i = 1'b1;
    drive(1'b1, 1'b0, 32'h1000_0024, 4'hF, 32'h0);
    #1;
    n_cmp++; if (data_rvalid_o !== 1'b0 || busy_o !== 1'b0) begin
      n_bad++; $display("FAIL drop_rvalid: rvalid=%b busy=%b want 0", data_rvalid_o, busy_o);
    end
    n_cmp++; if (data_rdata_o !== 32'h0) begin n_bad++; $display("FAIL drop_rdata: got %h want 0", data_rdata_o); end
    n_cmp++; if (sram_req_o !== 1'b0 || data_gnt_o !== 1'b0) begin
      n_bad++; $display("FAIL drop_req: sram_req=%b gnt=%b want 0", sram_req_o, data_gnt_o);
    end
    next_cycle();
    n_cmp++; if (rd_cnt_o !== 16'd0 || data_rvalid_o !== 1'b0) begin
      n_bad++; $display("FAIL drop_after: rd_cnt=%0d rvalid=%b want 0", rd_cnt_o, data_rvalid_o);
    end
    rst_i = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    next_cycle();
    n_cmp++; if (data_rvalid_o !== 1'b0) begin n_bad++; $display("FAIL drop_late: rvalid=%b want 0", data_rvalid_o); end
  endtask

  task automatic test_read();
    sram_gnt_i = 1'b1;
    sram_rdata_i = 32'h0;
    drive(1'b1, 1'b0, 32'h1000_0010, 4'hF, 32'h0);
    #1;
    n_cmp++; if (sram_req_o !== 1'b1 || data_gnt_o !== 1'b1 || sram_we_o !== 1'b0) begin
      n_bad++; $display("FAIL rd_req: sram_req=%b gnt=%b we=%b want 1 1 0", sram_req_o, data_gnt_o, sram_we_o);
    end
    n_cmp++; if (sram_addr_o !== 10'd4) begin n_bad++; $display("FAIL rd_addr: got %0d want 4", sram_addr_o); end
    n_cmp++; if (data_rvalid_o !== 1'b0) begin n_bad++; $display("FAIL rd_early: rvalid=%b want 0", data_rvalid_o); end
    next_cycle();
    exp_rd++;
    drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    sram_rdata_i = 32'hDEAD_BEEF;
    #1;
    n_cmp++; if (data_rvalid_o !== 1'b1 || data_err_o !== 1'b0 || busy_o !== 1'b1) begin
      n_bad++; $display("FAIL rd_rsp: rvalid=%b err=%b busy=%b want 1 0 1", data_rvalid_o, data_err_o, busy_o);
    end
    n_cmp++; if (data_rdata_o !== 32'hDEAD_BEEF) begin
      n_bad++; $display("FAIL rd_data: got %h want deadbeef", data_rdata_o);
    end
    n_cmp++; if (rd_cnt_o !== 16'(exp_rd)) begin n_bad++; $display("FAIL rd_cnt: got %0d want %0d", rd_cnt_o, exp_rd); end
    next_cycle();
    n_cmp++; if (data_rvalid_o !== 1'b0) begin n_bad++; $display("FAIL rd_single: rvalid=%b want 0", data_rvalid_o); end
  endtask

  task automatic test_write();
    sram_gnt_i = 1'b1;
    sram_rdata_i = 32'h5555_AAAA;
    drive(1'b1, 1'b1, 32'h1000_0FFC, 4'b0011, 32'h1234_5678);
    #1;
    n_cmp++; if (sram_req_o !== 1'b1 || sram_we_o !== 1'b1 || sram_be_o !== 4'b0011) begin
      n_bad++; $display("FAIL wr_req: req=%b we=%b be=%b want 1 1 0011", sram_req_o, sram_we_o, sram_be_o);
    end
    n_cmp++; if (sram_addr_o !== 10'd1023 || sram_wdata_o !== 32'h1234_5678) begin
      n_bad++; $display("FAIL wr_addr: addr=%0d wdata=%h want 1023 12345678", sram_addr_o, sram_wdata_o);
    end
    next_cycle();
    exp_wr++;
    // Zero byte enables is still a counted write.
    drive(1'b1, 1'b1, 32'h1000_0000, 4'b0000, 32'hFFFF_FFFF);
    #1;
    n_cmp++; if (data_rvalid_o !== 1'b1 || data_rdata_o !== 32'h0 || data_err_o !== 1'b0) begin
      n_bad++; $display("FAIL wr_rsp: rvalid=%b rdata=%h err=%b want 1 0 0", data_rvalid_o, data_rdata_o, data_err_o);
    end
    n_cmp++; if (wr_cnt_o !== 16'(exp_wr)) begin n_bad++; $display("FAIL wr_cnt: got %0d want %0d", wr_cnt_o, exp_wr); end
    n_cmp++; if (sram_req_o !== 1'b1 || sram_be_o !== 4'b0000) begin
      n_bad++; $display("FAIL wr_be0: req=%b be=%b want 1 0000", sram_req_o, sram_be_o);
    end
    next_cycle();
    exp_wr++;
    drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    n_cmp++; if (wr_cnt_o !== 16'(exp_wr) || data_rvalid_o !== 1'b1) begin
      n_bad++; $display("FAIL wr_be0_cnt: cnt=%0d rvalid=%b want %0d 1", wr_cnt_o, data_rvalid_o, exp_wr);
    end
    next_cycle();
  endtask

  task automatic test_error();
    sram_gnt_i = 1'b0;
    sram_rdata_i = 32'h7777_7777;
    drive(1'b1, 1'b0, 32'h1000_1000, 4'hF, 32'h0);
    #1;
    n_cmp++; if (data_gnt_o !== 1'b1 || sram_req_o !== 1'b0) begin
      n_bad++; $display("FAIL err_hi_req: gnt=%b sram_req=%b want 1 0", data_gnt_o, sram_req_o);
    end
    next_cycle();
    exp_err++;
    drive(1'b1, 1'b0, 32'h0FFF_FFFC, 4'hF, 32'h0);
    #1;
    n_cmp++; if (data_gnt_o !== 1'b1 || sram_req_o !== 1'b0) begin
      n_bad++; $display("FAIL err_lo_req: gnt=%b sram_req=%b want 1 0", data_gnt_o, sram_req_o);
    end
    n_cmp++; if (data_rvalid_o !== 1'b1 || data_err_o !== 1'b1 || data_rdata_o !== 32'h0) begin
      n_bad++; $display("FAIL err_hi_rsp: rvalid=%b err=%b rdata=%h want 1 1 0", data_rvalid_o, data_err_o, data_rdata_o);
    end
    next_cycle();
    exp_err++;
    drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    n_cmp++; if (data_rvalid_o !== 1'b1 || data_err_o !== 1'b1 || data_rdata_o !== 32'h0) begin
      n_bad++; $display("FAIL err_lo_rsp: rvalid=%b err=%b rdata=%h want 1 1 0", data_rvalid_o, data_err_o, data_rdata_o);
    end
    n_cmp++; if (err_cnt_o !== 16'(exp_err)) begin n_bad++; $display("FAIL err_cnt: got %0d want %0d", err_cnt_o, exp_err); end
    next_cycle();
  endtask

  task automatic test_stall();
    sram_gnt_i = 1'b0;
    drive(1'b1, 1'b0, 32'h1000_0040, 4'hF, 32'h0);
    for (int c = 0; c < 4; c++) begin
      if (c == 3) sram_gnt_i = 1'b1;
      #1;
      n_cmp++; if (data_gnt_o !== (c == 3)) begin
        n_bad++; $display("FAIL stall_gnt[%0d]: got %b want %b", c, data_gnt_o, c == 3);
      end
      n_cmp++; if (data_rvalid_o !== 1'b0 || rd_cnt_o !== 16'(exp_rd)) begin
        n_bad++; $display("FAIL stall_hold[%0d]: rvalid=%b cnt=%0d want 0 %0d", c, data_rvalid_o, rd_cnt_o, exp_rd);
      end
      next_cycle();
    end
    exp_rd++;
    drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    sram_rdata_i = 32'h0BAD_CAFE;
    #1;
    n_cmp++; if (data_rvalid_o !== 1'b1 || data_rdata_o !== 32'h0BAD_CAFE || rd_cnt_o !== 16'(exp_rd)) begin
      n_bad++; $display("FAIL stall_rsp: rvalid=%b rdata=%h cnt=%0d want 1 0badcafe %0d",
                        data_rvalid_o, data_rdata_o, rd_cnt_o, exp_rd);
    end
    next_cycle();
    n_cmp++; if (data_rvalid_o !== 1'b0) begin n_bad++; $display("FAIL stall_single: rvalid=%b want 0", data_rvalid_o); end
  endtask

  task automatic test_back_to_back();
    int prev_kind;
    logic [31:0] exp_data;
    prev_kind = -1;
    sram_gnt_i = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) begin
        case (i % 3)
          0:       drive(1'b1, 1'b0, 32'h1000_0000 + 32'(4 * i), 4'hF, 32'h0);
          1:       drive(1'b1, 1'b1, 32'h1000_0000 + 32'(4 * i), 4'hF, 32'(i));
          default: drive(1'b1, 1'b0, 32'h2000_0000, 4'hF, 32'h0);
        endcase
      end else begin
        drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      end
      sram_rdata_i = 32'hA5A5_0000 | 32'(i);
      #1;
      if (i < 8) begin
        n_cmp++; if (data_gnt_o !== 1'b1) begin n_bad++; $display("FAIL b2b_gnt[%0d]: got %b want 1", i, data_gnt_o); end
      end
      if (prev_kind >= 0) begin
        exp_data = (prev_kind == 0) ? (32'hA5A5_0000 | 32'(i)) : 32'h0;
        n_cmp++; if (data_rvalid_o !== 1'b1 || data_err_o !== (prev_kind == 2) || data_rdata_o !== exp_data) begin
          n_bad++; $display("FAIL b2b_rsp[%0d]: rvalid=%b err=%b rdata=%h want 1 %b %h",
                            i, data_rvalid_o, data_err_o, data_rdata_o, prev_kind == 2, exp_data);
        end
      end
      if (i < 8) begin
        prev_kind = i % 3;
        if (prev_kind == 0) exp_rd++;
        else if (prev_kind == 1) exp_wr++;
        else exp_err++;
      end
      next_cycle();
    end
    n_cmp++; if (data_rvalid_o !== 1'b0) begin n_bad++; $display("FAIL b2b_end: rvalid=%b want 0", data_rvalid_o); end
    n_cmp++; if (rd_cnt_o !== 16'(exp_rd) || wr_cnt_o !== 16'(exp_wr) || err_cnt_o !== 16'(exp_err)) begin
      n_bad++; $display("FAIL b2b_cnt: got %0d %0d %0d want %0d %0d %0d",
                        rd_cnt_o, wr_cnt_o, err_cnt_o, exp_rd, exp_wr, exp_err);
    end
    n_cmp++; if (s_rd_cnt !== 2'd3 || s_wr_cnt !== 2'd3 || s_err_cnt !== 2'd3) begin
      n_bad++; $display("FAIL b2b_sat: got %0d %0d %0d want 3 3 3", s_rd_cnt, s_wr_cnt, s_err_cnt);
    end
  endtask

  initial begin
    rst_i = 1'b1;
    sram_gnt_i = 1'b0;
    sram_rdata_i = 32'h0;
    drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    test_reset();
    test_saturation();
    test_reset_drop();
    test_read();
    test_write();
    test_error();
    test_stall();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
